// File: rtl/unidad_control.sv
// unidad_control: multi-cycle control FSM for the CS3 data unit.
// One FETCH cycle, 1-5 execute cycles decoded from (state, op), STOP parks in HALT.
module unidad_control #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] op,
  input  logic [2:0] condicion,
  input  logic [3:0] regestado,
  output logic       wir,
  output logic       ipc,
  output logic       clpc,
  output logic       wpc,
  output logic       rpc,
  output logic       wreg,
  output logic       wac,
  output logic       rac,
  output logic       wsreg,
  output logic       wmar,
  output logic       wmem,
  output logic       rmem,
  output logic       inm,
  output logic       s,
  output logic       r,
  output logic       ta,
  output logic       tb,
  output logic       enable_mux_carry,
  output logic       isp,
  output logic       dsp,
  output logic       rsp,
  output logic       prsp,
  output logic       halted
);
  typedef enum logic [2:0] {RST, FETCH, E1, E2, E3, E4, E5, HALT} state_t;
  localparam logic [4:0] OP_ST   = 5'b00000, OP_LD   = 5'b00001, OP_STS  = 5'b00010,
                         OP_LDS  = 5'b00011, OP_CALL = 5'b00100, OP_RET  = 5'b00101,
                         OP_BR   = 5'b00110, OP_JMP  = 5'b00111, OP_ADD  = 5'b01000,
                         OP_ADC  = 5'b01001, OP_SUB  = 5'b01010, OP_CP   = 5'b01011,
                         OP_MOV  = 5'b01111, OP_STOP = 5'b10111, OP_SUBI = 5'b11010,
                         OP_CPI  = 5'b11011, OP_SBCI = 5'b11100, OP_LDI  = 5'b11111;
  state_t     state_q, state_d;
  logic       e1, e2, e3, e4, e5, taken, legal, stop;
  logic [2:0] len, step;
  assign e1 = state_q == E1;
  assign e2 = state_q == E2;
  assign e3 = state_q == E3;
  assign e4 = state_q == E4;
  assign e5 = state_q == E5;
  assign step = state_q - 3'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= RST;
    else state_q <= state_d;
  always_comb begin
    taken = condicion == 3'd0 ? regestado[1] :
            condicion == 3'd1 ? regestado[3] :
            condicion == 3'd2 ? regestado[0] :
            condicion == 3'd3 ? regestado[2] ^ regestado[0] : 1'b0;
    legal = op inside {OP_ST, OP_LD, OP_STS, OP_LDS, OP_CALL, OP_RET, OP_BR, OP_JMP, OP_ADD,
                       OP_ADC, OP_SUB, OP_CP, OP_MOV, OP_STOP, OP_SUBI, OP_CPI, OP_SBCI, OP_LDI};
    stop = op == OP_STOP || (!legal && HALT_ON_ILLEGAL);
    case (op)
      OP_LDI, OP_MOV, OP_ADD, OP_ADC, OP_SUB, OP_SUBI, OP_SBCI, OP_JMP: len = 3'd2;
      OP_LD, OP_LDS, OP_RET: len = 3'd3;
      OP_ST, OP_STS:         len = 3'd4;
      OP_CALL:               len = 3'd5;
      OP_BR:                 len = taken ? 3'd2 : 3'd1;
      default:               len = 3'd1;
    endcase
    state_d = state_q;
    case (state_q)
      RST:     state_d = FETCH;
      FETCH:   state_d = E1;
      HALT:    state_d = HALT;
      default: state_d = (e1 && stop) ? HALT : step == len ? FETCH : state_t'(state_q + 3'd1);
    endcase
  end
  always_comb begin
    {wir, ipc, wpc, rpc, wreg, wac, rac, wsreg, wmar, wmem, rmem, inm} = '0;
    {s, r, ta, tb, enable_mux_carry, isp, dsp, rsp} = '0;
    clpc   = state_q == RST;
    prsp   = state_q == RST;
    wir    = state_q == FETCH;
    ipc    = state_q == FETCH;
    halted = state_q == HALT;
    case (op)
      OP_LDI, OP_MOV: begin
        inm = e1 && op == OP_LDI;
        {tb, wac} = {2{e1}};
        {rac, wreg} = {2{e2}};
      end
      OP_ADD, OP_ADC: begin
        {s, wac, wsreg} = {3{e1}};
        enable_mux_carry = e1 && op == OP_ADC;
        {rac, wreg} = {2{e2}};
      end
      OP_SUB, OP_SUBI, OP_SBCI: begin
        {r, wac, wsreg} = {3{e1}};
        inm = e1 && op != OP_SUB;
        enable_mux_carry = e1 && op == OP_SBCI;
        {rac, wreg} = {2{e2}};
      end
      OP_CP, OP_CPI: begin
        {r, wsreg} = {2{e1}};
        inm = e1 && op == OP_CPI;
      end
      OP_LD, OP_LDS: begin
        inm = e1 && op == OP_LDS;
        {tb, wac} = {2{e1}};
        {rac, wmar} = {2{e2}};
        {rmem, wreg} = {2{e3}};
      end
      OP_ST, OP_STS: begin
        inm = e1 && op == OP_STS;
        tb = e1;
        wac = e1 || e3;
        ta = e3;
        rac = e2 || e4;
        wmar = e2;
        wmem = e4;
      end
      OP_JMP, OP_BR: begin
        {inm, tb, wac} = {3{e1 && (op == OP_JMP || taken)}};
        {rac, wpc} = {2{e2}};
      end
      OP_CALL: begin
        {rsp, wmar} = {2{e1}};
        {rpc, wmem} = {2{e2}};
        dsp = e3;
        {inm, tb, wac} = {3{e4}};
        {rac, wpc} = {2{e5}};
      end
      OP_RET: begin
        isp = e1;
        {rsp, wmar} = {2{e2}};
        {rmem, wpc} = {2{e3}};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_unidad_control.sv
// tb_unidad_control: drives unidad_control with a behavioural CS3 data unit and
// scores its architectural effect against an instruction-level model.
module tb_unidad_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  localparam logic [4:0] OP_ST   = 5'b00000, OP_LD   = 5'b00001, OP_STS  = 5'b00010,
                         OP_LDS  = 5'b00011, OP_CALL = 5'b00100, OP_RET  = 5'b00101,
                         OP_BR   = 5'b00110, OP_JMP  = 5'b00111, OP_ADD  = 5'b01000,
                         OP_ADC  = 5'b01001, OP_SUB  = 5'b01010, OP_CP   = 5'b01011,
                         OP_MOV  = 5'b01111, OP_STOP = 5'b10111, OP_SUBI = 5'b11010,
                         OP_CPI  = 5'b11011, OP_SBCI = 5'b11100, OP_LDI  = 5'b11111;
  localparam logic [22:0] RSTV = 23'h100002;
  logic [4:0] legal_ops [17] = '{OP_ST, OP_LD, OP_STS, OP_LDS, OP_CALL, OP_RET, OP_BR, OP_JMP,
                                  OP_ADD, OP_ADC, OP_SUB, OP_CP, OP_MOV, OP_SUBI, OP_CPI, OP_SBCI, OP_LDI};
  logic [4:0] bad_ops [6] = '{5'b10000, 5'b10001, 5'b10010, 5'b11000, 5'b11110, 5'b01100};
  logic [4:0] op;
  logic [2:0] condicion;
  logic [3:0] regestado;
  logic wir, ipc, clpc, wpc, rpc, wreg, wac, rac, wsreg, wmar, wmem, rmem, inm;
  logic s, r, ta, tbs, emc, isp, dsp, rsp, prsp, halted;
  logic [22:0] outs;
  logic [2:0]  ndrv;
  assign outs = {wir, ipc, clpc, wpc, rpc, wreg, wac, rac, wsreg, wmar, wmem, rmem,
                 inm, s, r, ta, tbs, emc, isp, dsp, rsp, prsp, halted};
  assign ndrv = 3'(rac) + 3'(rpc) + 3'(rsp) + 3'(rmem);
  unidad_control dut (
    .clk(clk), .reset(reset), .op(op), .condicion(condicion), .regestado(regestado),
    .wir(wir), .ipc(ipc), .clpc(clpc), .wpc(wpc), .rpc(rpc), .wreg(wreg), .wac(wac),
    .rac(rac), .wsreg(wsreg), .wmar(wmar), .wmem(wmem), .rmem(rmem), .inm(inm),
    .s(s), .r(r), .ta(ta), .tb(tbs), .enable_mux_carry(emc), .isp(isp), .dsp(dsp),
    .rsp(rsp), .prsp(prsp), .halted(halted)
  );
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [11:0] alu(input logic sub, input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] t;
    logic v;
    t = sub ? {1'b0, a} - {1'b0, b} - {8'b0, ci} : {1'b0, a} + {1'b0, b} + {8'b0, ci};
    v = sub ? (a[7] != b[7]) && (t[7] != a[7]) : (a[7] == b[7]) && (t[7] != a[7]);
    return {t[8], t[7], t[7:0] == 8'h00, v, t[7:0]};
  endfunction
  function automatic logic [31:0] hash(input logic [7:0] m [256]);
    logic [31:0] h = 32'h1;
    for (int i = 0; i < 256; i++) h = h * 32'd31 + {24'b0, m[i]};
    return h;
  endfunction
  function automatic logic [63:0] pack(input logic [7:0] x [8]);
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = x[i];
    return p;
  endfunction
  function automatic logic [15:0] ins(input logic [4:0] o, input logic [2:0] d, input logic [7:0] k);
    return {o, d, k};
  endfunction
  // behavioural data unit: reacts only to the strobes
  logic [15:0] rom [256];
  logic [15:0] ir;
  logic [7:0]  pc, sp, ac, mar, bus, a_op, b_op;
  logic [3:0]  flg, i_flg;
  logic [7:0]  rf [8], i_rf [8];
  logic [7:0]  ram [256], i_ram [256];
  logic [11:0] alu_o;
  logic        ld = 1'b0;
  assign op = ir[15:11];
  assign condicion = ir[10:8];
  assign regestado = flg;
  assign a_op = rf[ir[10:8]];
  assign b_op = inm ? ir[7:0] : rf[ir[2:0]];
  always_comb begin
    alu_o = s ? alu(1'b0, a_op, b_op, emc & flg[3]) :
            r ? alu(1'b1, a_op, b_op, emc & flg[3]) :
            ta ? {2'b0, a_op == 8'h00, 1'b0, a_op} : {2'b0, b_op == 8'h00, 1'b0, b_op};
    bus = rac ? ac : rpc ? pc : rsp ? sp : rmem ? ram[mar] : 8'h00;
  end
  always @(posedge clk) begin
    if (ld) begin
      rf <= i_rf;
      ram <= i_ram;
      flg <= i_flg;
      ir <= '0;
    end
    if (wir) ir <= rom[pc];
    pc <= clpc ? 8'h00 : wpc ? bus : ipc ? pc + 8'd1 : pc;
    sp <= prsp ? 8'hFF : isp ? sp + 8'd1 : dsp ? sp - 8'd1 : sp;
    if (wac) ac <= alu_o[7:0];
    if (wsreg) flg <= alu_o[11:8];
    if (wreg) rf[ir[10:8]] <= bus;
    if (wmar) mar <= bus;
    if (wmem) ram[mar] <= bus;
  end
  // instruction-level reference model
  typedef struct packed {
    logic        halt;
    logic [3:0]  cyc;
    logic [7:0]  pc;
    logic [7:0]  sp;
    logic [3:0]  f;
    logic [63:0] regs;
    logic [31:0] mh;
  } snap_t;
  snap_t q[$];
  logic [7:0] m_pc, m_sp;
  logic [3:0] m_f;
  logic [7:0] m_rf [8];
  logic [7:0] m_ram [256];
  function automatic logic br_taken(input logic [2:0] c, input logic [3:0] f);
    logic [7:0] tk;
    tk = {4'b0, f[2] ^ f[0], f[0], f[3], f[1]};
    return tk[c];
  endfunction
  function automatic snap_t snap(input logic h, input logic [3:0] c);
    return '{halt: h, cyc: c, pc: m_pc, sp: m_sp, f: m_f, regs: pack(m_rf), mh: hash(m_ram)};
  endfunction
  task automatic model_step(output snap_t e);
    logic [15:0] w;
    logic [4:0]  o;
    logic [2:0]  d, rs;
    logic [7:0]  k, b;
    logic [11:0] t;
    logic [3:0]  cyc;
    logic        h;
    w = rom[m_pc];
    o = w[15:11]; d = w[10:8]; rs = w[2:0]; k = w[7:0];
    m_pc = m_pc + 8'd1;
    cyc = 4'd2;
    h = 1'b0;
    case (o)
      OP_LDI: begin m_rf[d] = k; cyc = 4'd3; end
      OP_MOV: begin m_rf[d] = m_rf[rs]; cyc = 4'd3; end
      OP_ADD, OP_ADC, OP_SUB, OP_SUBI, OP_SBCI, OP_CP, OP_CPI: begin
        b = (o == OP_SUBI || o == OP_SBCI || o == OP_CPI) ? k : m_rf[rs];
        t = alu(o != OP_ADD && o != OP_ADC, m_rf[d], b, (o == OP_ADC || o == OP_SBCI) & m_f[3]);
        m_f = t[11:8];
        if (o != OP_CP && o != OP_CPI) begin m_rf[d] = t[7:0]; cyc = 4'd3; end
      end
      OP_LD:   begin m_rf[d] = m_ram[m_rf[rs]]; cyc = 4'd4; end
      OP_LDS:  begin m_rf[d] = m_ram[k]; cyc = 4'd4; end
      OP_ST:   begin m_ram[m_rf[rs]] = m_rf[d]; cyc = 4'd5; end
      OP_STS:  begin m_ram[k] = m_rf[d]; cyc = 4'd5; end
      OP_JMP:  begin m_pc = k; cyc = 4'd3; end
      OP_BR:   if (br_taken(d, m_f)) begin m_pc = k; cyc = 4'd3; end
      OP_CALL: begin m_ram[m_sp] = m_pc; m_sp = m_sp - 8'd1; m_pc = k; cyc = 4'd6; end
      OP_RET:  begin m_sp = m_sp + 8'd1; m_pc = m_ram[m_sp]; cyc = 4'd4; end
      OP_STOP: h = 1'b1;
      default: ;
    endcase
    e = snap(h, cyc);
  endtask
  task automatic build_expect(input int n);
    snap_t e;
    m_pc = 8'h00; m_sp = 8'hFF; m_f = i_flg; m_rf = i_rf; m_ram = i_ram;
    q.push_back(snap(1'b0, 4'd0));
    for (int i = 0; i < n; i++) begin
      model_step(e);
      q.push_back(e);
      if (e.halt) break;
    end
  endtask
  // monitor: pops one snapshot per instruction boundary
  logic  mon_en = 1'b0;
  logic  hp = 1'b0;
  int    cyc_n = 0;
  snap_t me;
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_out", 64'(outs), 64'(RSTV));
      cyc_n <= 0;
      hp <= 1'b0;
    end else begin
      chk("one_bus_driver", 64'(ndrv > 3'd1), 64'd0);
      chk("wmem_rmem", 64'(wmem & rmem), 64'd0);
      if (halted) chk("halt_quiet", 64'(outs), 64'd1);
      if (mon_en && q.size() > 0 && (wir || (halted && !hp))) begin
        me = q.pop_front();
        chk("event_halt", 64'(halted), 64'(me.halt));
        if (me.cyc != 4'd0) chk("instr_cycles", 64'(cyc_n), 64'(me.cyc));
        chk("pc", 64'(pc), 64'(me.pc));
        chk("sp", 64'(sp), 64'(me.sp));
        chk("flags", 64'(flg), 64'(me.f));
        chk("regs", pack(rf), me.regs);
        chk("ram_hash", 64'(hash(ram)), 64'(me.mh));
        cyc_n <= 1;
      end else cyc_n <= cyc_n + 1;
      hp <= halted;
    end
  end
  task automatic begin_prog();
    @(posedge clk);
    #1 reset = 1'b1;
    ld = 1'b1;
    mon_en = 1'b0;
    q.delete();
    for (int i = 0; i < 256; i++) begin
      i_ram[i] = 8'($urandom);
      rom[i] = rnd_ins();
    end
    for (int i = 0; i < 8; i++) i_rf[i] = 8'($urandom);
    i_flg = 4'($urandom);
  endtask
  task automatic release_prog(input logic en);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ld = 1'b0;
    mon_en = en;
    @(negedge clk);
    chk("rst_state_out", 64'(outs), 64'(RSTV));
  endtask
  task automatic wait_drain(input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
    mon_en = 1'b0;
  endtask
  task automatic wait_wir(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wir && n < lim);
    chk("fetch_timeout", 64'(wir), 64'd1);
  endtask
  function automatic logic [15:0] rnd_ins();
    int p = $urandom_range(0, 99);
    logic [4:0] o = p < 2 ? OP_STOP : p < 8 ? bad_ops[$urandom_range(0, 5)] : legal_ops[$urandom_range(0, 16)];
    return ins(o, 3'($urandom), 8'($urandom));
  endfunction
  task automatic run(input int n);
    build_expect(n);
    release_prog(1'b1);
    wait_drain(n * 8 + 20);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    begin_prog();
    rom[0] = ins(OP_LDI, 3'd4, 8'd10);
    rom[1] = ins(OP_LDI, 3'd5, 8'd4);
    rom[2] = ins(OP_SUB, 3'd5, 8'd4);
    rom[3] = ins(OP_STOP, 3'd0, 8'd0);
    run(10);
    chk("sub_result", 64'(rf[5]), 64'hFA);
    chk("sub_flags", 64'(flg), 64'hC);
    repeat (4) @(negedge clk);
    chk("still_halted", 64'(halted), 64'd1);
    for (int t = 0; t < 2; t++) begin
      begin_prog();
      rom[0] = ins(OP_LDI, 3'd4, 8'd10);
      rom[1] = ins(OP_CPI, 3'd4, t == 0 ? 8'd10 : 8'd9);
      rom[2] = ins(OP_BR, 3'd0, 8'h20);
      rom[3] = ins(OP_STOP, 3'd0, 8'd0);
      rom[32] = ins(OP_STOP, 3'd0, 8'd0);
      run(10);
      chk("breq_pc", 64'(pc), t == 0 ? 64'h21 : 64'h04);
    end
    begin_prog();
    for (int i = 0; i < 5; i++) rom[i] = ins(OP_LDI, 3'd0, 8'd0);
    rom[5] = ins(OP_CALL, 3'd0, 8'h30);
    rom[6] = ins(OP_STOP, 3'd0, 8'd0);
    rom[48] = ins(OP_RET, 3'd0, 8'd0);
    run(12);
    chk("call_ret_addr", 64'(ram[255]), 64'd6);
    chk("call_sp", 64'(sp), 64'hFF);
    chk("ret_pc", 64'(pc), 64'd7);
    begin_prog();
    rom[0] = ins(OP_LDI, 3'd3, 8'h5A);
    rom[1] = ins(OP_STS, 3'd3, 8'h10);
    rom[2] = ins(OP_LDS, 3'd2, 8'h10);
    rom[3] = ins(OP_STOP, 3'd0, 8'd0);
    run(10);
    chk("lds_value", 64'(rf[2]), 64'h5A);
    begin_prog();
    rom[0] = ins(5'b10000, 3'd0, 8'd0);
    rom[1] = ins(OP_STOP, 3'd0, 8'd0);
    build_expect(4);
    release_prog(1'b1);
    wait_wir(5);
    @(negedge clk);
    chk("illegal_e1_quiet", 64'(outs), 64'd0);
    wait_drain(20);
    begin_prog();
    rom[0] = ins(OP_ST, 3'd1, 8'd2);
    i_rf[1] = 8'h5A;
    i_rf[2] = 8'h40;
    i_ram[64] = 8'h00;
    release_prog(1'b0);
    wait_wir(5);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("async_reset_out", 64'(outs), 64'(RSTV));
    repeat (3) begin
      @(negedge clk);
      chk("no_wmem_after_reset", 64'(wmem), 64'd0);
    end
    chk("st_aborted_ram", 64'(ram[64]), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_wir(5);
    @(posedge clk);
    #1 chk("restart_ir", 64'(ir), 64'(rom[0]));
    chk("restart_pc", 64'(pc), 64'd1);
    for (int p = 0; p < 40; p++) begin
      begin_prog();
      run(40);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
